// File: rtl/regfile_4r2w_mux.sv
// 32x64 register file: two write ports, four read addresses
// funnelled through one priority-selected, registered output.
module regfile_4r2w_mux #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        read,
  input  logic [1:0]        write,
  input  logic [ADDR_W-1:0] read_port_1,
  input  logic [ADDR_W-1:0] read_port_2,
  input  logic [ADDR_W-1:0] read_port_3,
  input  logic [ADDR_W-1:0] read_port_4,
  input  logic [ADDR_W-1:0] write_port_1,
  input  logic [ADDR_W-1:0] write_port_2,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  output logic [DATA_W-1:0] out
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] out_d;

  // Port 2 is applied last so it wins a same-address collision.
  always_comb begin
    mem_d = mem_q;
    if (write[0]) mem_d[write_port_1] = in1;
    if (write[1]) mem_d[write_port_2] = in2;
  end

  // Reads see mem_q, i.e. pre-write contents.
  always_comb begin
    out_d = out_q;
    priority case (1'b1)
      read[0]: out_d = mem_q[read_port_1];
      read[1]: out_d = mem_q[read_port_2];
      read[2]: out_d = mem_q[read_port_3];
      read[3]: out_d = mem_q[read_port_4];
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      out_q <= '0;
    end else begin
      mem_q <= mem_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_regfile_4r2w_mux.sv
// Bench for regfile_4r2w_mux: directed table, reset
// corner cases and a randomized run against an array model.
module tb_regfile_4r2w_mux;

  logic        clk;
  logic        rst_n;
  logic [3:0]  read;
  logic [1:0]  write;
  logic [4:0]  read_port_1;
  logic [4:0]  read_port_2;
  logic [4:0]  read_port_3;
  logic [4:0]  read_port_4;
  logic [4:0]  write_port_1;
  logic [4:0]  write_port_2;
  logic [63:0] in1;
  logic [63:0] in2;
  logic [63:0] out;

  regfile_4r2w_mux dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .read         (read),
    .write        (write),
    .read_port_1  (read_port_1),
    .read_port_2  (read_port_2),
    .read_port_3  (read_port_3),
    .read_port_4  (read_port_4),
    .write_port_1 (write_port_1),
    .write_port_2 (write_port_2),
    .in1          (in1),
    .in2          (in2),
    .out          (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  rd;
    logic [1:0]  wr;
    logic [4:0]  rp1, rp2, rp3, rp4;
    logic [4:0]  wp1, wp2;
    logic [63:0] d1, d2;
    logic [63:0] exp;
  } vec_t;

  vec_t vt [17];

  int n_cmp;
  int n_bad;

  logic [63:0] m [32];
  logic [63:0] m_out;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] rd, input logic [1:0] wr,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] r3, input logic [4:0] r4,
                       input logic [4:0] w1, input logic [4:0] w2,
                       input logic [63:0] d1, input logic [63:0] d2);
    read = rd;
    write = wr;
    read_port_1 = r1;
    read_port_2 = r2;
    read_port_3 = r3;
    read_port_4 = r4;
    write_port_1 = w1;
    write_port_2 = w2;
    in1 = d1;
    in2 = d2;
  endtask

  task automatic idle();
    drive(4'b0, 2'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0);
  endtask

  task automatic step_vec(input vec_t v);
    @(negedge clk);
    drive(v.rd, v.wr, v.rp1, v.rp2, v.rp3, v.rp4,
          v.wp1, v.wp2, v.d1, v.d2);
    @(posedge clk);
    #1;
    chk(v.name, out, v.exp);
  endtask

  // Model: the selected read sees the array before this cycle's writes.
  task automatic model_step();
    logic [4:0] ra [4];
    bit hit;
    ra[0] = read_port_1;
    ra[1] = read_port_2;
    ra[2] = read_port_3;
    ra[3] = read_port_4;
    hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!hit && read[k]) begin
        m_out = m[ra[k]];
        hit = 1'b1;
      end
    end
    if (write[0]) m[write_port_1] = in1;
    if (write[1]) m[write_port_2] = in2;
  endtask

  function automatic logic [4:0] raddr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    rst_n = 1'b1;

    vt[0]  = '{"rd_reset_reg7", 4'b0001, 2'b00, 5'd7, 5'd0, 5'd0, 5'd0,
               5'd0, 5'd0, 64'd0, 64'd0, 64'd0};
    vt[1]  = '{"wr_single", 4'b0000, 2'b01, 5'd0, 5'd0, 5'd0, 5'd0,
               5'd3, 5'd0, 64'hDEADBEEF_00000001, 64'd0, 64'd0};
    vt[2]  = '{"rd_single", 4'b0001, 2'b00, 5'd3, 5'd0, 5'd0, 5'd0,
               5'd0, 5'd0, 64'd0, 64'd0, 64'hDEADBEEF_00000001};
    vt[3]  = '{"wr_dual", 4'b0000, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0,
               5'd5, 5'd9, 64'h11, 64'h22, 64'hDEADBEEF_00000001};
    vt[4]  = '{"rd_dual_5", 4'b0001, 2'b00, 5'd5, 5'd0, 5'd0, 5'd0,
               5'd0, 5'd0, 64'd0, 64'd0, 64'h11};
    vt[5]  = '{"rd_dual_9", 4'b0001, 2'b00, 5'd9, 5'd0, 5'd0, 5'd0,
               5'd0, 5'd0, 64'd0, 64'd0, 64'h22};
    vt[6]  = '{"wr_collide", 4'b0000, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0,
               5'd12, 5'd12, 64'hAA, 64'hBB, 64'h22};
    vt[7]  = '{"rd_collide", 4'b0001, 2'b00, 5'd12, 5'd0, 5'd0, 5'd0,
               5'd0, 5'd0, 64'd0, 64'd0, 64'hBB};
    vt[8]  = '{"pre_12", 4'b0000, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0,
               5'd1, 5'd2, 64'd1, 64'd2, 64'hBB};
    vt[9]  = '{"pre_34", 4'b0000, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0,
               5'd3, 5'd4, 64'd3, 64'd4, 64'hBB};
    vt[10] = '{"prio_1110", 4'b1110, 2'b00, 5'd1, 5'd2, 5'd3, 5'd4,
               5'd0, 5'd0, 64'd0, 64'd0, 64'd2};
    vt[11] = '{"prio_1000", 4'b1000, 2'b00, 5'd1, 5'd2, 5'd3, 5'd4,
               5'd0, 5'd0, 64'd0, 64'd0, 64'd4};
    vt[12] = '{"prio_1111", 4'b1111, 2'b00, 5'd1, 5'd2, 5'd3, 5'd4,
               5'd0, 5'd0, 64'd0, 64'd0, 64'd1};
    vt[13] = '{"hold_0000", 4'b0000, 2'b00, 5'd1, 5'd2, 5'd3, 5'd4,
               5'd0, 5'd0, 64'd0, 64'd0, 64'd1};
    vt[14] = '{"pre_6", 4'b0000, 2'b01, 5'd0, 5'd0, 5'd0, 5'd0,
               5'd6, 5'd0, 64'h5, 64'd0, 64'd1};
    vt[15] = '{"rdw_old", 4'b0001, 2'b01, 5'd6, 5'd0, 5'd0, 5'd0,
               5'd6, 5'd0, 64'h6, 64'd0, 64'h5};
    vt[16] = '{"rdw_new", 4'b0001, 2'b00, 5'd6, 5'd0, 5'd0, 5'd0,
               5'd0, 5'd0, 64'd0, 64'd0, 64'h6};

    // Asynchronous reset asserted mid-cycle.
    #3 rst_n = 1'b0;
    #1 chk("reset_async", out, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("reset_release", out, 64'd0);

    for (int i = 0; i < 17; i++) begin
      step_vec(vt[i]);
    end

    // Mid-operation reset: out clears at once, pending write is dropped.
    @(negedge clk);
    drive(4'b0001, 2'b01, 5'd6, 5'd0, 5'd0, 5'd0,
          5'd20, 5'd0, 64'h77, 64'd0);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_out", out, 64'd0);
    @(posedge clk);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    step_vec('{"reset_clr_12", 4'b0001, 2'b00, 5'd12, 5'd0, 5'd0, 5'd0,
               5'd0, 5'd0, 64'd0, 64'd0, 64'd0});
    step_vec('{"reset_no_wr20", 4'b0001, 2'b00, 5'd20, 5'd0, 5'd0, 5'd0,
               5'd0, 5'd0, 64'd0, 64'd0, 64'd0});

    // Randomized run from the all-zero post-reset state.
    for (int i = 0; i < 32; i++) m[i] = 64'd0;
    m_out = out;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      drive(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            raddr(), raddr(), raddr(), raddr(), raddr(), raddr(),
            {$urandom, $urandom}, {$urandom, $urandom});
      model_step();
      @(posedge clk);
      #1;
      chk("random", out, m_out);
    end

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
